// File: rtl/uart_tx_frame.sv
// UART frame serialiser: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Bit boundaries are driven by the baud generator's one-clock baud_pulse strobe.
module uart_tx_frame #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_pulse,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] PENDING = 3'd1;
  localparam logic [2:0] START   = 3'd2;
  localparam logic [2:0] DATA    = 3'd3;
  localparam logic [2:0] PARITY  = 3'd4;
  localparam logic [2:0] STOP    = 3'd5;

  localparam int             IW        = $clog2(DATA_BITS);
  localparam logic [IW-1:0]  LAST_BIT  = IW'(DATA_BITS - 1);
  localparam logic           STOP_LAST = (STOP_BITS == 2);
  localparam logic           ODD       = (PARITY_ODD != 0);

  logic [2:0]           state;
  logic [DATA_BITS-1:0] shreg;
  logic [IW-1:0]        bit_idx;
  logic                 stop_cnt;
  logic                 par;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      par      <= 1'b0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (tx_valid) begin
            shreg    <= tx_data;
            par      <= (^tx_data) ^ ODD;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b1;
            state    <= PENDING;
          end
        end
        // Wait for a fresh pulse so the start bit is never truncated.
        PENDING: if (baud_pulse) begin
          tx    <= 1'b0;
          state <= START;
        end
        // The shift register always presents the next data bit at bit 0.
        START: if (baud_pulse) begin
          tx      <= shreg[0];
          shreg   <= shreg >> 1;
          bit_idx <= '0;
          state   <= DATA;
        end
        DATA: if (baud_pulse) begin
          if (bit_idx != LAST_BIT) begin
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + IW'(1);
          end else if (PARITY_EN != 0) begin
            tx    <= par;
            state <= PARITY;
          end else begin
            tx       <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= STOP;
          end
        end
        PARITY: if (baud_pulse) begin
          tx       <= 1'b1;
          stop_cnt <= 1'b0;
          state    <= STOP;
        end
        STOP: if (baud_pulse) begin
          tx <= 1'b1;
          if (stop_cnt == STOP_LAST) begin
            tx_done  <= 1'b1;
            tx_busy  <= 1'b0;
            tx_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            stop_cnt <= 1'b1;
          end
        end
        default: begin
          tx       <= 1'b1;
          tx_ready <= 1'b1;
          tx_busy  <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
